// File: rtl/four_bits_pkg.sv
// ---------------------------------------------------------------------------
// four_bits_pkg
//   Shared constants and types for the four_bits core and its program loader.
//   Contents:
//     WORD_W, DEPTH, PC_W  - instruction width, program depth, PC width
//     CNT_W                - word counter width (one bit wider than PC_W so
//                            that DEPTH itself is representable)
//     FRAME_W, BIT_CNT_W   - serial frame length (data + parity) and the
//                            width of its bit counter
//     PAR_ODD              - parity mode constant
//     state_t              - loader FSM state encoding
//     parity_ok()          - frame parity check
// ---------------------------------------------------------------------------
package four_bits_pkg;

  localparam int WORD_W    = 5;
  localparam int DEPTH     = 16;
  localparam int PC_W      = 4;
  localparam int CNT_W     = PC_W + 1;
  localparam int FRAME_W   = WORD_W + 1;
  localparam int BIT_CNT_W = 3;

  localparam logic PAR_ODD = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // A frame is good when the XOR over data and parity bits equals PAR_ODD.
  function automatic logic parity_ok(input logic [FRAME_W-1:0] frame);
    return (^frame) == PAR_ODD;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Multi-flop synchronizer for one edge-detected input plus a bundle of
//   level inputs, all delayed by the same number of stages so they stay
//   aligned with each other in the clk domain.
//   Ports:
//     clk        in   system clock
//     clear      in   synchronous active-high reset
//     edge_in    in   asynchronous input whose rising edges are detected
//     level_in   in   asynchronous level inputs (LEVEL_W bits)
//     level_sync out  synchronized level inputs
//     rise       out  one-clk pulse per rising edge of edge_in
//   SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module sync_edge_det #(
  parameter int                 SYNC_STAGES = 2,
  parameter int                 LEVEL_W     = 1,
  parameter logic [LEVEL_W-1:0] LEVEL_IDLE  = '0
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               edge_in,
  input  logic [LEVEL_W-1:0] level_in,
  output logic [LEVEL_W-1:0] level_sync,
  output logic               rise
);

  logic [LEVEL_W-1:0] level_q [SYNC_STAGES];
  logic               edge_q  [SYNC_STAGES];
  logic               edge_prev_q;

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples the value its predecessor held before this clock edge; blocking
  // assignments would collapse the chain into a single flop.
  // NOTE: the synchronizer chain is reset to the idle link levels, so
  // releasing clear can never fabricate a ser_clk edge or a frame start.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        level_q[i] <= LEVEL_IDLE;
        edge_q[i]  <= 1'b0;
      end
      edge_prev_q <= 1'b0;
    end else begin
      level_q[0] <= level_in;
      edge_q[0]  <= edge_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        level_q[i] <= level_q[i-1];
        edge_q[i]  <= edge_q[i-1];
      end
      edge_prev_q <= edge_q[SYNC_STAGES-1];
    end
  end

  assign level_sync = level_q[SYNC_STAGES-1];
  assign rise       = edge_q[SYNC_STAGES-1] & ~edge_prev_q;

endmodule

// File: rtl/serial_prog_loader.sv
// ---------------------------------------------------------------------------
// serial_prog_loader
//   Receives 6-bit frames (5 data bits MSB first, then an odd parity bit)
//   over a 3-wire serial link and hands each good word to prog_input with a
//   one-cycle write strobe, until DEPTH words have been loaded.
//   Ports:
//     clk        in   system clock
//     clear      in   synchronous active-high reset
//     ser_clk    in   serial clock (async), data sampled on its rising edge
//     ser_data   in   serial data, MSB first
//     ser_cs_n   in   frame select, active-low
//     instruc    out  accepted word, stable from one cycle before enable
//     enable     out  one-clk write strobe per accepted word
//     word_count out  words accepted since clear (0..DEPTH, CNT_W bits)
//     load_done  out  sticky, DEPTH words accepted
//     frame_err  out  sticky, parity error, aborted word or edge overrun
//     busy       out  a word is being shifted, checked or written
// ---------------------------------------------------------------------------
module serial_prog_loader
  import four_bits_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              ser_clk,
  input  logic              ser_data,
  input  logic              ser_cs_n,
  output logic [WORD_W-1:0] instruc,
  output logic              enable,
  output logic [CNT_W-1:0]  word_count,
  output logic              load_done,
  output logic              frame_err,
  output logic              busy
);

  logic                 cs_n_s, data_s, ser_rise;

  state_t               state_q,     state_d;
  logic [FRAME_W-1:0]   shift_q,     shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [WORD_W-1:0]    instruc_q,   instruc_d;
  logic [CNT_W-1:0]     count_q,     count_d;
  logic                 done_q,      done_d;
  logic                 err_q,       err_d;
  logic                 pend_q,      pend_d;
  logic                 pend_data_q, pend_data_d;
  logic                 enable_q;
  logic                 bit_in;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .LEVEL_W     (2),
    .LEVEL_IDLE  (2'b10)
  ) u_sync (
    .clk        (clk),
    .clear      (clear),
    .edge_in    (ser_clk),
    .level_in   ({ser_cs_n, ser_data}),
    .level_sync ({cs_n_s, data_s}),
    .rise       (ser_rise)
  );

  // NOTE: every variable gets its hold value first, so paths that do not
  // mention a signal keep it unchanged instead of inferring a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    instruc_d   = instruc_q;
    count_d     = count_q;
    done_d      = done_q;
    err_d       = err_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    bit_in      = data_s;

    // Edges arriving while no bit can be shifted are parked for SHIFT.
    if (ser_rise && (state_q == CHECK || state_q == WRITE ||
                     (state_q == IDLE && !cs_n_s))) begin
      if (pend_q) begin
        err_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = data_s;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!cs_n_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end else begin
          pend_d = 1'b0;
        end
      end

      SHIFT: begin
        if (cs_n_s) begin
          if (bit_cnt_q != '0) err_d = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
        end else if (pend_q || ser_rise) begin
          // A parked edge is older than a fresh one; both at once is overrun.
          bit_in  = pend_q ? pend_data_q : data_s;
          if (pend_q && ser_rise) err_d = 1'b1;
          pend_d  = 1'b0;
          shift_d = {shift_q[FRAME_W-2:0], bit_in};
          if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      CHECK: begin
        if (parity_ok(shift_q)) begin
          instruc_d = shift_q[FRAME_W-1:1];
          state_d   = WRITE;
        end else begin
          err_d = 1'b1;
          if (cs_n_s) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      WRITE: begin
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(DEPTH - 1)) begin
          done_d  = 1'b1;
          state_d = DONE;
          pend_d  = 1'b0;
        end else begin
          state_d = SHIFT;
        end
      end

      DONE: begin
        pend_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // enable is registered from WRITE so instruc (loaded on entry to WRITE)
  // leads it by one cycle, and count/done/enable all change together.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      instruc_q   <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      instruc_q   <= instruc_d;
      count_q     <= count_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      enable_q    <= (state_q == WRITE);
    end
  end

  assign instruc    = instruc_q;
  assign enable     = enable_q;
  assign word_count = count_q;
  assign load_done  = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q == SHIFT && bit_cnt_q != '0) ||
                      (state_q == CHECK) || (state_q == WRITE);

endmodule

// File: tb/tb_serial_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_serial_prog_loader
//   Self-checking bench for serial_prog_loader. A word-level model (queue of
//   expected words, accepted count, sticky error flag) is updated by the
//   stimulus tasks; a negedge monitor checks every enable pulse against it.
// ---------------------------------------------------------------------------
module tb_serial_prog_loader;
  import four_bits_pkg::*;

  logic              clk;
  logic              clear;
  logic              ser_clk;
  logic              ser_data;
  logic              ser_cs_n;
  logic [WORD_W-1:0] instruc;
  logic              enable;
  logic [CNT_W-1:0]  word_count;
  logic              load_done;
  logic              frame_err;
  logic              busy;

  serial_prog_loader #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .clear      (clear),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .ser_cs_n   (ser_cs_n),
    .instruc    (instruc),
    .enable     (enable),
    .word_count (word_count),
    .load_done  (load_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Word-level reference model.
  logic [WORD_W-1:0] exp_q [$];
  int                model_cnt = 0;
  bit                model_err = 1'b0;
  int                seen      = 0;
  bit                in_clear  = 1'b1;
  logic              enable_prev  = 1'b0;
  logic [WORD_W-1:0] instruc_prev = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model effect of a complete frame whose parity bit has just been clocked.
  task automatic model_word(input logic [WORD_W-1:0] d, input bit good);
    if (model_cnt < DEPTH) begin
      if (good) begin
        exp_q.push_back(d);
        model_cnt++;
      end else begin
        model_err = 1'b1;
      end
    end
  endtask

  task automatic model_abort(input int nbits);
    if (model_cnt < DEPTH && nbits >= 1 && nbits < FRAME_W) model_err = 1'b1;
  endtask

  task automatic ser_bit(input logic b, input int lo, input int hi);
    ser_data = b;
    repeat (lo) @(posedge clk);
    #2 ser_clk = 1'b1;
    repeat (hi) @(posedge clk);
    #2 ser_clk = 1'b0;
  endtask

  // Sends one frame; jitter widens each half period beyond 4 clk cycles.
  // lat_chk pins enable timing: high exactly at the 5th clk edge after the
  // parity pin edge (2 sync stages + edge detect + CHECK + WRITE).
  task automatic send_word(input logic [WORD_W-1:0] d, input bit good,
                           input int jitter, input bit lat_chk);
    logic [FRAME_W-1:0] frame;
    logic               p;
    p = ~(^d);
    if (!good) p = ~p;
    frame = {d, p};
    for (int i = FRAME_W - 1; i >= 1; i--)
      ser_bit(frame[i], 4 + int'($urandom_range(0, jitter)),
              4 + int'($urandom_range(0, jitter)));
    ser_data = frame[0];
    repeat (4 + int'($urandom_range(0, jitter))) @(posedge clk);
    #2 ser_clk = 1'b1;
    model_word(d, good);
    if (lat_chk) begin
      repeat (4) @(posedge clk);
      #1;
      check("lat_enable_early", int'(enable), 0);
      check("lat_instruc_setup", int'(instruc), int'(d));
      @(posedge clk);
      #1;
      check("lat_enable_on_time", int'(enable), 1);
      check("lat_count", int'(word_count), model_cnt);
      @(posedge clk);
      #1;
      check("lat_enable_width", int'(enable), 0);
      @(posedge clk);
    end else begin
      repeat (4 + int'($urandom_range(0, jitter))) @(posedge clk);
    end
    #2 ser_clk = 1'b0;
  endtask

  task automatic frame_start();
    @(posedge clk);
    #2 ser_cs_n = 1'b0;
  endtask

  task automatic frame_end();
    repeat (4) @(posedge clk);
    #2 ser_cs_n = 1'b1;
  endtask

  task automatic apply_clear();
    @(posedge clk);
    #2 clear = 1'b1;
    in_clear = 1'b1;
    @(posedge clk);
    #1;
    check("clr_instruc", int'(instruc), 0);
    check("clr_enable", int'(enable), 0);
    check("clr_count", int'(word_count), 0);
    check("clr_done", int'(load_done), 0);
    check("clr_err", int'(frame_err), 0);
    check("clr_busy", int'(busy), 0);
    #1 clear = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    model_err = 1'b0;
    seen      = 0;
    in_clear  = 1'b0;
  endtask

  task automatic settle_checks(input string tag);
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_enables"}, seen, model_cnt);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_count"}, int'(word_count), model_cnt);
    check({tag, "_err"}, int'(frame_err), int'(model_err));
    check({tag, "_done"}, int'(load_done), int'(model_cnt == DEPTH));
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: every enable pulse must deliver the oldest outstanding word.
  always @(negedge clk) begin
    if (!in_clear && enable) begin
      check("enable_width", int'(enable_prev), 0);
      check("instruc_setup", int'(instruc), int'(instruc_prev));
      seen++;
      check("queue_at_enable", exp_q.size(), 1);
      if (exp_q.size() != 0) check("instruc", int'(instruc), int'(exp_q.pop_front()));
      check("count_at_enable", int'(word_count), seen);
      check("done_at_enable", int'(load_done), int'(seen == DEPTH));
    end
    enable_prev  = enable;
    instruc_prev = instruc;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear    = 1'b1;
    ser_clk  = 1'b0;
    ser_data = 1'b0;
    ser_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_instruc", int'(instruc), 0);
    check("rst_enable", int'(enable), 0);
    check("rst_count", int'(word_count), 0);
    check("rst_done", int'(load_done), 0);
    check("rst_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    #1 clear = 1'b0;
    in_clear = 1'b0;

    // Single good word with enable timing.
    frame_start();
    send_word(5'b10110, 1'b1, 0, 1'b1);
    frame_end();
    settle_checks("t2");
    check("t2_instruc_lit", int'(instruc), 22);
    check("t2_count_lit", int'(word_count), 1);

    // Bad parity then good word in the same frame.
    frame_start();
    send_word(5'b00011, 1'b0, 0, 1'b0);
    send_word(5'b00001, 1'b1, 0, 1'b0);
    frame_end();
    settle_checks("t3");
    check("t3_err_lit", int'(frame_err), 1);
    check("t3_count_lit", int'(word_count), 2);
    check("t3_instruc_lit", int'(instruc), 1);

    // Clear in the middle of a word; next word loads as word 0.
    frame_start();
    ser_bit(1'b1, 4, 4);
    ser_bit(1'b0, 4, 4);
    ser_bit(1'b1, 4, 4);
    apply_clear();
    send_word(5'b01101, 1'b1, 2, 1'b0);
    frame_end();
    settle_checks("t1");
    check("t1_count_lit", int'(word_count), 1);

    // Abort after 4 bits, then a realigned good word.
    frame_start();
    ser_bit(1'b1, 4, 4);
    ser_bit(1'b1, 4, 4);
    ser_bit(1'b0, 4, 4);
    ser_bit(1'b0, 4, 4);
    repeat (2) @(posedge clk);
    #2 ser_cs_n = 1'b1;
    model_abort(4);
    repeat (10) @(posedge clk);
    #1;
    check("t4_err_lit", int'(frame_err), 1);
    check("t4_busy_idle", int'(busy), 0);
    check("t4_count_hold", int'(word_count), 1);
    frame_start();
    send_word(5'b11100, 1'b1, 2, 1'b0);
    frame_end();
    settle_checks("t4");

    // Full load at f_ser_clk = f_clk/8, then one extra word.
    apply_clear();
    frame_start();
    for (int i = 0; i < DEPTH + 1; i++)
      send_word(WORD_W'($urandom_range(0, 31)), 1'b1, 0, 1'b0);
    frame_end();
    settle_checks("t5");
    check("t5_count_lit", int'(word_count), 16);
    check("t5_done_lit", int'(load_done), 1);

    // Random gaps and parity, possibly across the DEPTH boundary.
    for (int run = 0; run < 2; run++) begin
      apply_clear();
      frame_start();
      for (int i = 0; i < 12 + run * 10; i++)
        send_word(WORD_W'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, 4, 1'b0);
      frame_end();
      settle_checks("t6");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
